// File: rtl/pyr_pkg.sv
// Shared definitions for the pyramidal (excitatory) end of the PING E-I loop:
// FSM state codes, Q4.14 constants and the default data-path saturation bounds.
package pyr_pkg;

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_SPIKE     = 2'd1,
        ST_REFRACT   = 2'd2
    } pyr_state_t;

    localparam int Q_WIDTH = 18;
    localparam int Q_FRAC  = 14;
    localparam int ONE     = 1 << Q_FRAC;
    localparam int HALF    = ONE / 2;
    localparam int SAT_MAX = (1 << (Q_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (Q_WIDTH - 1));

endpackage

// File: rtl/leaky_integrator_q14.sv
// Combinational leaky-integrator step: v_next = sat(v + ((sat(net - v) * TAU_INV) >>> FRAC)).
// Every intermediate is saturated to the signed WIDTH range, so nothing wraps.
module leaky_integrator_q14 #(
    parameter int WIDTH   = 18,
    parameter int FRAC    = 14,
    parameter int TAU_INV = 410
) (
    input  logic signed [WIDTH-1:0] net,
    input  logic signed [WIDTH-1:0] v,
    output logic signed [WIDTH-1:0] v_next
);

    localparam int XW = WIDTH + 32;
    localparam logic signed [XW-1:0] MAXV  = {{33{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV  = {{33{1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [XW-1:0] TAU_X = XW'(TAU_INV);

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] x);
        if (x > MAXV) begin
            return MAXV[WIDTH-1:0];
        end else if (x < MINV) begin
            return MINV[WIDTH-1:0];
        end
        return x[WIDTH-1:0];
    endfunction

    logic signed [XW-1:0]    net_x;
    logic signed [XW-1:0]    v_x;
    logic signed [WIDTH-1:0] drv;
    logic signed [XW-1:0]    drv_x;
    logic signed [XW-1:0]    prod_x;
    logic signed [XW-1:0]    delta_x;

    assign net_x   = {{32{net[WIDTH-1]}}, net};
    assign v_x     = {{32{v[WIDTH-1]}}, v};
    assign drv     = sat(net_x - v_x);
    assign drv_x   = {{32{drv[WIDTH-1]}}, drv};
    assign prod_x  = drv_x * TAU_X;
    // Arithmetic shift: negative deltas round toward minus infinity.
    assign delta_x = prod_x >>> FRAC;
    assign v_next  = sat(v_x + delta_x);

endmodule

// File: rtl/pyramidal_spike_unit.sv
// Excitatory pyramidal cell: integrates drive minus PV+ inhibition into a leaky
// membrane and runs the integrate / spike / refractory FSM on each clk_en tick.
module pyramidal_spike_unit
    import pyr_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int FRAC        = 14,
    parameter int TAU_INV     = 410,
    parameter int THRESH      = HALF,
    parameter int V_RESET     = 0,
    parameter int SPIKE_AMP   = ONE,
    parameter int SPIKE_LEN   = 2,
    parameter int REFRACT_LEN = 8,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] drive_input,
    input  logic signed [WIDTH-1:0] inhibition,
    output logic signed [WIDTH-1:0] pyramid_out,
    output logic                    spike_pulse,
    output logic [1:0]              fsm_state,
    output logic [CNT_W-1:0]        spike_count,
    output logic signed [WIDTH-1:0] v_state_out
);

    localparam int TW = 16;
    localparam logic signed [WIDTH-1:0] THRESH_V    = WIDTH'(THRESH);
    localparam logic signed [WIDTH-1:0] V_RESET_V   = WIDTH'(V_RESET);
    localparam logic signed [WIDTH-1:0] SPIKE_AMP_V = WIDTH'(SPIKE_AMP);
    localparam logic [TW-1:0] SPIKE_LAST   = TW'(SPIKE_LEN - 1);
    localparam logic [TW-1:0] REFRACT_LAST = (REFRACT_LEN > 0) ? TW'(REFRACT_LEN - 1) : '0;
    localparam logic signed [WIDTH-1:0] NET_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] NET_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    pyr_state_t              state_q, state_d;
    logic [TW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] v_q, v_d;
    logic                    pulse_d;
    logic [CNT_W-1:0]        count_d;

    logic signed [WIDTH:0]   net_wide;
    logic signed [WIDTH-1:0] net;
    logic signed [WIDTH-1:0] v_next;

    // One extra bit holds any difference exactly; the top two bits disagree only on overflow.
    assign net_wide = {drive_input[WIDTH-1], drive_input} - {inhibition[WIDTH-1], inhibition};
    assign net = (net_wide[WIDTH] != net_wide[WIDTH-1])
               ? (net_wide[WIDTH] ? NET_MIN : NET_MAX)
               : net_wide[WIDTH-1:0];

    leaky_integrator_q14 #(
        .WIDTH  (WIDTH),
        .FRAC   (FRAC),
        .TAU_INV(TAU_INV)
    ) u_integrator (
        .net   (net),
        .v     (v_q),
        .v_next(v_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INTEGRATE;
            cnt_q       <= '0;
            v_q         <= V_RESET_V;
            spike_pulse <= 1'b0;
            spike_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            v_q         <= v_d;
            spike_pulse <= pulse_d;
            spike_count <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        pulse_d = 1'b0;
        count_d = spike_count;
        if (clk_en) begin
            case (state_q)
                ST_SPIKE: begin
                    v_d = V_RESET_V;
                    if (cnt_q == '0) begin
                        if (REFRACT_LEN == 0) begin
                            state_d = ST_INTEGRATE;
                        end else begin
                            state_d = ST_REFRACT;
                            cnt_d   = REFRACT_LAST;
                        end
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                ST_REFRACT: begin
                    v_d = V_RESET_V;
                    if (cnt_q == '0) begin
                        state_d = ST_INTEGRATE;
                    end else begin
                        cnt_d = cnt_q - TW'(1);
                    end
                end
                // The unused code 3 integrates like ST_INTEGRATE.
                default: begin
                    if (v_next >= THRESH_V) begin
                        state_d = ST_SPIKE;
                        cnt_d   = SPIKE_LAST;
                        v_d     = V_RESET_V;
                        pulse_d = 1'b1;
                        if (spike_count != '1) begin
                            count_d = spike_count + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_INTEGRATE;
                        v_d     = v_next;
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (state_q)
            ST_SPIKE:   pyramid_out = SPIKE_AMP_V;
            ST_REFRACT: pyramid_out = V_RESET_V;
            default:    pyramid_out = v_q;
        endcase
    end

    assign fsm_state   = state_q;
    assign v_state_out = v_q;

endmodule

// File: tb/tb_pyramidal_spike_unit.sv
// Scoreboard bench for pyramidal_spike_unit: default instance plus a fast
// instance (alpha = 1, one-tick spike, no refractory period).
module tb_pyramidal_spike_unit;
    import pyr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clk_en;
    logic signed [17:0] drv0, inh0, drv1, inh1;
    logic signed [17:0] out0, out1, v0, v1;
    logic pulse0, pulse1;
    logic [1:0] st0, st1;
    logic [15:0] cnt0, cnt1;

    pyramidal_spike_unit dut0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .drive_input(drv0), .inhibition(inh0),
        .pyramid_out(out0), .spike_pulse(pulse0), .fsm_state(st0),
        .spike_count(cnt0), .v_state_out(v0)
    );

    pyramidal_spike_unit #(
        .TAU_INV(16384),
        .SPIKE_LEN(1),
        .REFRACT_LEN(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .drive_input(drv1), .inhibition(inh1),
        .pyramid_out(out1), .spike_pulse(pulse1), .fsm_state(st1),
        .spike_count(cnt1), .v_state_out(v1)
    );

    typedef struct {
        longint v;
        longint out;
        int     st;
        int     pulse;
        int     cnt;
        int     idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last0, last1, e0, e1;

    // Reference model: phase 0 = integrate, 1 = spike, 2 = refractory; left = ticks remaining.
    longint m_v[2];
    int     m_ph[2];
    int     m_left[2];
    int     m_cnt[2];
    int     m_tau[2]  = '{410, 16384};
    int     m_slen[2] = '{2, 1};
    int     m_rlen[2] = '{8, 0};

    int n_chk = 0;
    int n_fail = 0;
    int tick_idx = 0;
    int first_spike = -1;
    bit sat_phase = 1'b0;

    function automatic longint clamp(longint x);
        if (x > SAT_MAX) return SAT_MAX;
        if (x < SAT_MIN) return SAT_MIN;
        return x;
    endfunction

    function automatic longint vnext(longint v, longint d, longint i, longint tau);
        longint net;
        longint drv;
        net = clamp(d - i);
        drv = clamp(net - v);
        return clamp(v + ((drv * tau) >>> 14));
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input longint v, input longint o,
                       input int st, input int p, input int c);
        chk({tag, "_v"}, v, e.v);
        chk({tag, "_out"}, o, e.out);
        chk({tag, "_state"}, st, e.st);
        chk({tag, "_pulse"}, p, e.pulse);
        chk({tag, "_count"}, c, e.cnt);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_ph[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
        end
        last0 = '{v: 0, out: 0, st: 0, pulse: 0, cnt: 0, idx: 0};
        last1 = last0;
    endtask

    task automatic model_tick(input int k, input longint d, input longint i, output exp_t e);
        int p;
        longint vn;
        p = 0;
        case (m_ph[k])
            0: begin
                vn = vnext(m_v[k], d, i, m_tau[k]);
                if (vn >= HALF) begin
                    m_ph[k] = 1; m_left[k] = m_slen[k]; m_v[k] = 0; p = 1;
                    if (m_cnt[k] < 65535) m_cnt[k]++;
                end else begin
                    m_v[k] = vn;
                end
            end
            1: begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    if (m_rlen[k] > 0) begin
                        m_ph[k] = 2; m_left[k] = m_rlen[k];
                    end else begin
                        m_ph[k] = 0;
                    end
                end
            end
            default: begin
                m_left[k]--;
                if (m_left[k] == 0) m_ph[k] = 0;
            end
        endcase
        e.v     = m_v[k];
        e.out   = (m_ph[k] == 0) ? m_v[k] : ((m_ph[k] == 1) ? longint'(ONE) : 0);
        e.st    = m_ph[k];
        e.pulse = p;
        e.cnt   = m_cnt[k];
        e.idx   = tick_idx;
    endtask

    task automatic tick(input int d0, input int i0, input int d1, input int i1);
        exp_t ea, eb;
        @(negedge clk);
        drv0 = 18'(d0); inh0 = 18'(i0); drv1 = 18'(d1); inh1 = 18'(i1);
        clk_en = 1'b1;
        if (rst_n) begin
            tick_idx++;
            model_tick(0, d0, i0, ea);
            model_tick(1, d1, i1, eb);
            q0.push_back(ea);
            q1.push_back(eb);
        end
        @(posedge clk);
        #1 clk_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 16384));
            1:       return int'($urandom_range(0, 262143)) - 131072;
            2:       return int'($urandom_range(0, 32768)) - 16384;
            default: return int'($urandom_range(8000, 20000));
        endcase
    endfunction

    // Monitor: a tick edge pops one expectation per instance; other edges must hold.
    always begin : monitor
        logic en_s, rst_s;
        @(posedge clk);
        en_s = clk_en;
        rst_s = rst_n;
        #2;
        if (en_s && rst_s) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb0_underflow: got no expectation, expected one queued");
            end else begin
                e0 = q0.pop_front();
                cmp("d0", e0, v0, out0, int'(st0), int'(pulse0), int'(cnt0));
                if (pulse0 && first_spike < 0) first_spike = e0.idx;
                last0 = e0; last0.pulse = 0;
            end
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb1_underflow: got no expectation, expected one queued");
            end else begin
                e1 = q1.pop_front();
                cmp("d1", e1, v1, out1, int'(st1), int'(pulse1), int'(cnt1));
                last1 = e1; last1.pulse = 0;
            end
        end else begin
            cmp("d0_hold", last0, v0, out0, int'(st0), int'(pulse0), int'(cnt0));
            cmp("d1_hold", last1, v1, out1, int'(st1), int'(pulse1), int'(cnt1));
        end
        if (sat_phase) chk("v_nonneg", (v0 < 0) ? 1 : 0, 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel;
        bit found;
        rst_n = 1'b0; clk_en = 1'b0;
        drv0 = 18'sd13107; inh0 = '0; drv1 = '0; inh1 = '0;
        model_reset();

        // Reset held while ticks arrive
        repeat (3) tick(13107, 0, 4000, 0);
        chk("rst_v", v0, 0);
        chk("rst_state", int'(st0), 0);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_out", out0, 0);
        chk("rst_pulse", int'(pulse0), 0);
        @(negedge clk) rst_n = 1'b1;

        // Tonic drive
        repeat (60) tick(13107, 0, int'($urandom_range(0, 12000)), 0);
        idle(1);
        chk("first_spike_in_36_42", (first_spike >= 36 && first_spike <= 42) ? 1 : 0, 1);

        // PV+ suppression
        repeat (2000) tick(13107, 8192, rnd_val(), rnd_val());

        // Saturating inputs
        sat_phase = 1'b1;
        repeat (6) tick(131071, -131072, 131071, -131072);
        idle(1);
        sat_phase = 1'b0;

        // Gating while in SPIKE
        for (int n = 0; n < 60 && m_ph[0] != 1; n++) tick(131071, -131072, 0, 0);
        if (m_ph[0] != 1) begin
            n_chk++; n_fail++;
            $display("FAIL reach_spike: got phase %0d, expected 1", m_ph[0]);
        end
        idle(100);
        repeat (12) tick(0, 0, 0, 0);
        for (int n = 0; n < 20 && (m_ph[0] != 0 || m_ph[1] != 0); n++) tick(0, 0, 0, 0);

        // Exact-threshold inputs on both instances
        repeat (20) tick(13107, 0, 0, 0);
        found = 1'b0; sel = 0;
        for (int d = 0; d <= SAT_MAX && !found; d++) begin
            if (vnext(m_v[0], d, 0, 410) == HALF) begin
                sel = d; found = 1'b1;
            end
        end
        if (!found) begin
            n_chk++; n_fail++;
            $display("FAIL eq_search: got no drive hitting 8192, expected one");
        end
        tick(sel, 0, 8191, 0);
        tick(0, 0, 8192, 0);
        repeat (3) tick(0, 0, 0, 0);

        // Randomised traffic with idle gaps
        repeat (400) begin
            tick(rnd_val(), rnd_val(), rnd_val(), rnd_val());
            idle(int'($urandom_range(0, 2)));
        end

        // Asynchronous reset in REFRACT, between edges
        for (int n = 0; n < 200 && m_ph[0] != 2; n++) tick(131071, -131072, 131071, -131072);
        tick(0, 0, 0, 0);
        if (m_ph[0] != 2) begin
            n_chk++; n_fail++;
            $display("FAIL reach_refract: got phase %0d, expected 2", m_ph[0]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_v", v0, 0);
        chk("arst_state", int'(st0), 0);
        chk("arst_count", int'(cnt0), 0);
        chk("arst_out", out0, 0);
        chk("arst_pulse", int'(pulse0), 0);
        chk("arst_count1", int'(cnt1), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (30) tick(rnd_val(), rnd_val(), rnd_val(), rnd_val());

        idle(3);
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
